// File: rtl/subtree_arb_pkg.sv
// rtl/subtree_arb_pkg.sv - shared types and default constants for the subtree round-robin arbiter
package subtree_arb_pkg;

    // Default fan-out of one node of the generated hierarchy
    localparam int SUBTREE_FANOUT   = 5;
    // Default grant length limit, only meaningful with SUBTREE_ARB_TIMEOUT_EN
    localparam int SUBTREE_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first request strictly after last_idx, wrapping
module rr_pick #(
    parameter int N_REQ = 5,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk last_idx+1 .. last_idx+N_REQ (mod N_REQ) and keep the first hit
    always_comb begin
        winner   = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_idx) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any    = 1'b1;
                winner = cand_idx;
            end
        end
    end

endmodule

// File: rtl/subtree_rr_arbiter.sv
// rtl/subtree_rr_arbiter.sv - round-robin arbiter for subtree siblings; optional hold limit via SUBTREE_ARB_TIMEOUT_EN
module subtree_rr_arbiter
    import subtree_arb_pkg::*;
#(
    parameter int N_REQ    = SUBTREE_FANOUT,
    parameter int MAX_HOLD = SUBTREE_MAX_HOLD,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_done;

`ifdef SUBTREE_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD >= 2);
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .last_idx (last_idx_q),
        .winner   (pick_idx),
        .any      (pick_any)
    );

    // Only the current owner's rel/req matter; everyone else is ignored
    assign owner_done = rel[gnt_idx_q] | ~req[gnt_idx_q];

    // Next-state: arbitrate in IDLE, hold in GRANT, one dead cycle in TURN
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
`ifdef SUBTREE_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d         = GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_idx_d       = pick_idx;
                    last_idx_d      = pick_idx;
`ifdef SUBTREE_ARB_TIMEOUT_EN
                    hold_cnt_d      = '0;
`endif
                end
            end
            GRANT: begin
`ifdef SUBTREE_ARB_TIMEOUT_EN
                if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`endif
                if (owner_done) begin
                    gnt_d   = '0;
                    state_d = TURN;
                end
`ifdef SUBTREE_ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    gnt_d     = '0;
                    state_d   = TURN;
                    timeout_d = 1'b1;
                end
`endif
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset points the pointer at the last requester so 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(N_REQ - 1);
`ifdef SUBTREE_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
`ifdef SUBTREE_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign busy      = (state_q != IDLE);
`ifdef SUBTREE_ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// tb/tb_subtree_rr_arbiter.sv - self-checking bench for subtree_rr_arbiter against a behavioural model
module tb_subtree_rr_arbiter;

    localparam int N        = 5;
    localparam int MAX_HOLD = 16;
    localparam int IDX_W    = 3;
`ifdef SUBTREE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     rel = '0;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy;
    logic             timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: who owns the resource, how long, and the round-robin pointer
    int m_owner;
    int m_turn;
    int m_last;
    int m_idx;
    int m_age;
    int m_timeout;

    subtree_rr_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = -1;
        m_turn    = 0;
        m_last    = N - 1;
        m_idx     = 0;
        m_age     = 0;
        m_timeout = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        m_timeout = 0;
        if (m_owner >= 0) begin
            m_age = m_age + 1;
            if (l[m_owner] || !r[m_owner]) begin
                m_owner = -1;
                m_turn  = 1;
            end else if (TO_EN && m_age == MAX_HOLD) begin
                m_owner   = -1;
                m_turn    = 1;
                m_timeout = 1;
            end
        end else if (m_turn != 0) begin
            m_turn = 0;
        end else if (r != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && r[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                end
            end
            m_idx  = m_owner;
            m_last = m_owner;
            m_age  = 0;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] e;
        e = '0;
        if (m_owner >= 0) e[m_owner] = 1'b1;
        return e;
    endfunction

    function automatic logic [N+IDX_W+2:0] exp_outs();
        logic [N-1:0] e;
        e = exp_gnt();
        return {e, (e != '0), IDX_W'(m_idx), (m_owner >= 0 || m_turn != 0), (m_timeout != 0)};
    endfunction

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] l);
        req = r;
        rel = l;
        @(posedge clk);
        model_step(r, l);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        req = '0;
        rel = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        req = 5'b10110;
        rel = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (gnt !== 5'b0) $display("FAIL reset_gnt got %b want 00000", gnt); else n_pass++;
        n_checks++;
        if (gnt_valid !== 1'b0) $display("FAIL reset_gnt_valid got %b want 0", gnt_valid); else n_pass++;
        n_checks++;
        if (gnt_idx !== 3'd0) $display("FAIL reset_gnt_idx got %0d want 0", gnt_idx); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else n_pass++;
        req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_grant();
        logic ok;
        apply_reset();
        tick(5'b00100, 5'b00000);
        n_checks++;
        if (gnt !== 5'b00100 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_first_grant got gnt=%b idx=%0d valid=%b busy=%b want gnt=00100 idx=2 valid=1 busy=1",
                     gnt, gnt_idx, gnt_valid, busy);
        else n_pass++;
        tick(5'b00100, 5'b00000);
        tick(5'b00100, 5'b00100);
        n_checks++;
        if (gnt !== 5'b0 || busy !== 1'b1)
            $display("FAIL single_release got gnt=%b busy=%b want gnt=00000 busy=1", gnt, busy);
        else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(5'b00000, 5'b00000);
            if (gnt !== 5'b0 || gnt_idx !== 3'd2) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL single_idle_hold got gnt=%b idx=%0d want gnt=00000 idx=2", gnt, gnt_idx);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int order[$];
        int zero_run;
        int age;
        int bad_gap;
        logic [N-1:0] prev;
        logic multi;
        apply_reset();
        zero_run = 0;
        age      = 0;
        bad_gap  = 0;
        multi    = 1'b0;
        prev     = '0;
        for (int c = 0; c < 200 && order.size() < 6; c++) begin
            tick(5'b11111, (age == 3) ? gnt : 5'b00000);
            if ($countones(gnt) > 1) multi = 1'b1;
            if (gnt != '0 && prev == '0) begin
                if (order.size() > 0 && zero_run != 2) bad_gap++;
                order.push_back(int'(gnt_idx));
                age = 1;
            end else if (gnt != '0) begin
                age++;
            end
            if (gnt == '0) zero_run++; else zero_run = 0;
            prev = gnt;
        end
        n_checks++;
        if (order.size() != 6) $display("FAIL rotate_count got %0d grants want 6", order.size());
        else n_pass++;
        for (int k = 0; k < order.size(); k++) begin
            n_checks++;
            if (order[k] != k % N) $display("FAIL rotate_order_%0d got %0d want %0d", k, order[k], k % N);
            else n_pass++;
        end
        n_checks++;
        if (bad_gap != 0) $display("FAIL rotate_gap got %0d bad gaps want 0", bad_gap); else n_pass++;
        n_checks++;
        if (multi) $display("FAIL rotate_onehot got multi-hot grant want one-hot or zero"); else n_pass++;
    endtask

    task automatic test_nonowner_ignored();
        apply_reset();
        tick(5'b00010, 5'b00000);
        n_checks++;
        if (gnt !== 5'b00010) $display("FAIL nonowner_grant1 got %b want 00010", gnt); else n_pass++;
        tick(5'b01010, 5'b01000);
        tick(5'b01010, 5'b00000);
        n_checks++;
        if (gnt !== 5'b00010) $display("FAIL nonowner_rel3 got %b want 00010", gnt); else n_pass++;
        tick(5'b01000, 5'b00000);
        n_checks++;
        if (gnt !== 5'b0 || busy !== 1'b1) $display("FAIL nonowner_drop got gnt=%b busy=%b want 00000 1", gnt, busy);
        else n_pass++;
        tick(5'b01000, 5'b00000);
        tick(5'b01000, 5'b00000);
        n_checks++;
        if (gnt !== 5'b01000 || gnt_idx !== 3'd3)
            $display("FAIL nonowner_next got gnt=%b idx=%0d want 01000 3", gnt, gnt_idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        tick(5'b10000, 5'b00000);
        tick(5'b10000, 5'b00000);
        n_checks++;
        if (gnt !== 5'b10000) $display("FAIL midreset_pre got %b want 10000", gnt); else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (gnt !== 5'b0 || gnt_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_async got gnt=%b valid=%b busy=%b want 00000 0 0", gnt, gnt_valid, busy);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5'b10001, 5'b00000);
        n_checks++;
        if (gnt !== 5'b00001 || gnt_idx !== 3'd0)
            $display("FAIL midreset_restart got gnt=%b idx=%0d want 00001 0", gnt, gnt_idx);
        else n_pass++;
    endtask

`ifdef SUBTREE_ARB_TIMEOUT_EN
    task automatic test_hold_limit();
        int hi;
        int to;
        int nxt;
        apply_reset();
        hi  = 0;
        to  = 0;
        nxt = -1;
        for (int c = 0; c < 60 && nxt < 0; c++) begin
            tick(5'b01100, 5'b00000);
            if (gnt[2]) hi++;
            if (timeout) to++;
            if (gnt != '0 && !gnt[2]) nxt = int'(gnt_idx);
        end
        n_checks++;
        if (hi != MAX_HOLD) $display("FAIL hold_len got %0d want %0d", hi, MAX_HOLD); else n_pass++;
        n_checks++;
        if (to != 1) $display("FAIL hold_timeout_pulses got %0d want 1", to); else n_pass++;
        n_checks++;
        if (nxt != 3) $display("FAIL hold_next got %0d want 3", nxt); else n_pass++;
    endtask
`else
    task automatic test_no_hold_limit();
        int hi;
        int to;
        apply_reset();
        hi = 0;
        to = 0;
        for (int c = 0; c < 100; c++) begin
            tick(5'b01100, 5'b00000);
            if (gnt === 5'b00100) hi++;
            if (timeout !== 1'b0) to++;
        end
        n_checks++;
        if (hi != 100) $display("FAIL nohold_len got %0d want 100", hi); else n_pass++;
        n_checks++;
        if (to != 0) $display("FAIL nohold_timeout got %0d want 0", to); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic [N+IDX_W+2:0] got;
        logic [N+IDX_W+2:0] want;
        int errs;
        apply_reset();
        errs = 0;
        r = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            l = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            tick(r, l);
            got  = {gnt, gnt_valid, gnt_idx, busy, timeout};
            want = exp_outs();
            n_checks++;
            if (got !== want) begin
                if (errs < 10)
                    $display("FAIL random_cycle_%0d got gnt/valid/idx/busy/to=%b want %b", c, got, want);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_rotation();
        test_nonowner_ignored();
        test_reset_mid_grant();
`ifdef SUBTREE_ARB_TIMEOUT_EN
        test_hold_limit();
`else
        test_no_hold_limit();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/subtree_rr_arbiter.md
Name: subtree_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. a common bus or config port) among the N_REQ sibling instances of a subtree node. The default of 5 matches the five-child fan-out of the generated hierarchy.
- Instantiated once per parent node, beside its child instances.
- Grants exactly one requester at a time and holds the grant until that requester releases it.
- Enforces a one-cycle turnaround between grants.

Parameters:
- N_REQ, 5, number of requesters (2..16).
- MAX_HOLD, 16, maximum grant length in cycles; used only with the optional feature (>=2).
- IDX_W, $clog2(N_REQ), width of the index fields (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- rel  in  N_REQ  per-requester release strobe; single cycle, sampled only for the current owner.
- gnt  out  N_REQ  one-hot grant, or zero when idle.
- gnt_valid  out  1  OR of gnt.
- gnt_idx  out  IDX_W  index of the owner; holds its last value while idle.
- busy  out  1  high in the GRANT and TURN states.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit; constant 0 without the feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: gnt=0, gnt_valid=0, gnt_idx=0, busy=0, timeout=0, state=IDLE, last_idx=N_REQ-1 (requester 0 wins first), hold_cnt=0.
- All outputs are registered. There is no combinational path from req or rel to any output.
- FSM states: IDLE, GRANT, TURN.
- IDLE, when req != 0:
  - Winner = first set bit searching upward from last_idx+1, wrapping modulo N_REQ.
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_idx=winner, last_idx=winner, hold_cnt=0.
  - Grant latency is one cycle from req sampled high.
- IDLE, when req == 0: remain in IDLE with all outputs idle.
- GRANT, release conditions: rel[gnt_idx]=1, or req[gnt_idx]=0 (request withdrawn).
  - On either, next edge: gnt=0, state=TURN.
  - rel or req changes from non-owners are ignored.
  - hold_cnt increments every GRANT cycle and saturates at MAX_HOLD.
- TURN: exactly one cycle with gnt=0, then IDLE.
  - IDLE arbitrates in that same next cycle, so the minimum gap between two grants is 2 cycles with gnt low.
- Fairness:
  - last_idx updates only when a grant is issued.
  - A requester that withdrew still advances the pointer.
  - With all N_REQ requesting continuously, grants rotate 0,1,2,...,N_REQ-1,0.
- Single requester: receives repeated grants separated by the turnaround.
- Simultaneous rel and req-drop from the owner: treated as one release.
- A rel pulse while in IDLE or TURN is ignored.
- Reset mid-grant: gnt drops asynchronously. After reset, arbitration restarts from requester 0.

Optional Feature:
- Macro: SUBTREE_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt reaches MAX_HOLD-1 with no release, the next edge forces gnt=0, enters TURN and pulses timeout for one cycle.
  - The grant therefore lasts exactly MAX_HOLD cycles.
  - The revoked requester keeps its position (pointer already advanced), so it is served again only after the others.
- Undefined:
  - hold_cnt logic is removed and timeout is tied to 0.
  - A grant may last indefinitely.

Decomposition:
- Package subtree_arb_pkg holds:
  - arb_state_e enum (IDLE, GRANT, TURN).
  - Default constants SUBTREE_FANOUT=5 and SUBTREE_MAX_HOLD=16.
- Sub-module rr_pick: combinational rotate-priority-encoder. Inputs req and last_idx; outputs winner index and any.
- The FSM and registers stay in subtree_rr_arbiter.

Test Plan:
1. Reset, then req=5'b00100 held → gnt=5'b00100 and gnt_idx=2 one cycle after req is sampled; rel[2] pulse → gnt=0 next cycle; gnt stays 0 for ≥2 cycles while req=0.
2. req=5'b11111 held with each owner pulsing rel 3 cycles into its grant → grant order 0,1,2,3,4,0 with exactly two gnt-low cycles between grants; gnt always one-hot or zero.
3. Owner 1 drops req without rel; rel[3] pulsed by non-owner → grant ends only on req[1] fall; rel[3] has no effect; next winner is 3 when req=5'b01000.
4. rst_n asserted low mid-grant on requester 4 → gnt=0 immediately, without waiting for a clock; after release with req=5'b10001 → requester 0 is granted first.
5. With SUBTREE_ARB_TIMEOUT_EN and MAX_HOLD=16: requester 2 holds req with no rel → gnt[2] high exactly 16 cycles, timeout pulses once, requester 3 (also requesting) is granted next.
6. Without the macro, same stimulus as scenario 5 → gnt[2] stays high for 100 cycles and timeout stays 0.
